// File: rtl/apb_master_pkg.sv
// Shared state encoding and width helpers for the APB4 master bridge.
package apb_master_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apb_state_e;

   function automatic int strb_width(input int data_w);
      return data_w / 8;
   endfunction

   function automatic int sel_width(input int nslv);
      return (nslv > 1) ? $clog2(nslv) : 1;
   endfunction

   localparam int DEF_DATA_W = 32;
   localparam int DEF_NSLV   = 4;
   localparam int DEF_STRB_W = strb_width(DEF_DATA_W);
   localparam int DEF_SEL_W  = sel_width(DEF_NSLV);

endpackage

// File: rtl/apb_psel_decode.sv
// One-hot APB slave-select decode; drives all zeros while sel_en is low.
module apb_psel_decode
   import apb_master_pkg::*;
#(
   parameter int NSLV  = DEF_NSLV,
   parameter int SEL_W = sel_width(NSLV)
) (
   input  logic [SEL_W-1:0] sel_idx,
   input  logic             sel_en,
   output logic [NSLV-1:0]  sel
);

   always_comb begin
      sel = '0;
      if (sel_en) sel[sel_idx] = 1'b1;
   end

endmodule

// File: rtl/apb_master_ctrl.sv
// APB4 master bridge: valid/ready request port to SETUP/ACCESS transfers on NSLV slaves.
// Define APB_MASTER_TIMEOUT_EN to abort ACCESS after TIMEOUT wait cycles with an error response.
module apb_master_ctrl
   import apb_master_pkg::*;
#(
   parameter int ADDR_W  = 12,
   parameter int DATA_W  = 32,
   parameter int NSLV    = 4,
   parameter int TIMEOUT = 16
) (
   input  logic                  PCLK,
   input  logic                  PRESETn,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [ADDR_W-1:0]     req_addr,
   input  logic [DATA_W-1:0]     req_wdata,
   input  logic [DATA_W/8-1:0]   req_strb,
   output logic                  rsp_valid,
   output logic [DATA_W-1:0]     rsp_rdata,
   output logic                  rsp_err,
   output logic [NSLV-1:0]       PSEL,
   output logic                  PENABLE,
   output logic                  PWRITE,
   output logic [ADDR_W-1:0]     PADDR,
   output logic [DATA_W-1:0]     PWDATA,
   output logic [DATA_W/8-1:0]   PSTRB,
   input  logic [DATA_W-1:0]     PRDATA,
   input  logic                  PREADY,
   input  logic                  PSLVERR
);

   localparam int SW = sel_width(NSLV);

   apb_state_e    state;
   logic [SW-1:0] sel_idx;
   logic          tmo_hit;

   // Slave index comes from the latched address, so PSEL is stable for the whole transfer.
   assign sel_idx = PADDR[ADDR_W-1 -: SW];

   apb_psel_decode #(
      .NSLV  (NSLV),
      .SEL_W (SW)
   ) u_psel_decode (
      .sel_idx (sel_idx),
      .sel_en  (state != IDLE),
      .sel     (PSEL)
   );

`ifdef APB_MASTER_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   logic [CNT_W-1:0] wait_cnt;

   assign tmo_hit = (state == ACCESS) && (wait_cnt == CNT_W'(TIMEOUT));

   always_ff @(posedge PCLK) begin
      if (!PRESETn)
         wait_cnt <= '0;
      else if (state == SETUP)
         wait_cnt <= '0;
      else if ((state == ACCESS) && !PREADY && !tmo_hit)
         wait_cnt <= wait_cnt + 1'b1;
   end
`else
   // Without the counter no abort exists; any legal TIMEOUT (>=1) makes this constant 0.
   assign tmo_hit = (TIMEOUT < 1);
`endif

   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         state     <= IDLE;
         req_ready <= 1'b1;
         PENABLE   <= 1'b0;
         PWRITE    <= 1'b0;
         PADDR     <= '0;
         PWDATA    <= '0;
         PSTRB     <= '0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         rsp_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (req_valid) begin
                  PADDR     <= req_addr;
                  PWRITE    <= req_write;
                  PWDATA    <= req_wdata;
                  PSTRB     <= req_write ? req_strb : '0;
                  req_ready <= 1'b0;
                  state     <= SETUP;
               end
            end
            SETUP: begin
               PENABLE <= 1'b1;
               state   <= ACCESS;
            end
            ACCESS: begin
               // A ready slave wins over a timeout that expires in the same cycle.
               if (PREADY || tmo_hit) begin
                  PENABLE   <= 1'b0;
                  req_ready <= 1'b1;
                  rsp_valid <= 1'b1;
                  rsp_err   <= PREADY ? PSLVERR : 1'b1;
                  rsp_rdata <= (PREADY && !PWRITE) ? PRDATA : '0;
                  state     <= IDLE;
               end
            end
            default: begin
               PENABLE   <= 1'b0;
               req_ready <= 1'b1;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Self-checking bench for apb_master_ctrl: directed vector table, corner sequences, random transfers.
module tb_apb_master_ctrl;

   localparam int AW  = 12;
   localparam int DW  = 32;
   localparam int NS  = 4;
   localparam int TMO = 8;

   logic            PCLK = 1'b0;
   logic            PRESETn = 1'b0;
   logic            req_valid = 1'b0;
   logic            req_ready;
   logic            req_write = 1'b0;
   logic [AW-1:0]   req_addr = '0;
   logic [DW-1:0]   req_wdata = '0;
   logic [DW/8-1:0] req_strb = '0;
   logic            rsp_valid;
   logic [DW-1:0]   rsp_rdata;
   logic            rsp_err;
   logic [NS-1:0]   PSEL;
   logic            PENABLE;
   logic            PWRITE;
   logic [AW-1:0]   PADDR;
   logic [DW-1:0]   PWDATA;
   logic [DW/8-1:0] PSTRB;
   logic [DW-1:0]   PRDATA = '0;
   logic            PREADY = 1'b0;
   logic            PSLVERR = 1'b0;

   apb_master_ctrl #(.ADDR_W(AW), .DATA_W(DW), .NSLV(NS), .TIMEOUT(TMO)) dut (
      .PCLK(PCLK), .PRESETn(PRESETn),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
      .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA), .PREADY(PREADY),
      .PSLVERR(PSLVERR)
   );

   always #5 PCLK = ~PCLK;

   typedef struct {
      bit          wr;
      logic [11:0] addr;
      logic [31:0] wdata;
      logic [3:0]  strb;
      int          nwait;
      logic [31:0] prdata;
      bit          slverr;
      logic [3:0]  e_psel;
      logic [3:0]  e_pstrb;
      logic [31:0] e_rdata;
      bit          e_err;
   } vec_t;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] last_rdata = '0;
   logic        last_err = 1'b0;
   vec_t        tbl[6];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
      end
   endtask

   // Reference model: expectations straight from the bridge's transfer rules.
   function automatic vec_t model(bit wr, logic [11:0] a, logic [31:0] d, logic [3:0] s,
                                  int nw, logic [31:0] prd, bit err);
      vec_t v;
      v.wr = wr; v.addr = a; v.wdata = d; v.strb = s; v.nwait = nw;
      v.prdata = prd; v.slverr = err;
      v.e_psel  = 4'b0001 << a[11:10];
      v.e_pstrb = wr ? s : 4'h0;
      v.e_rdata = wr ? 32'h0 : prd;
      v.e_err   = err;
      return v;
   endfunction

   // Entered and left #1 after a rising edge; the request is accepted on the first edge.
   task automatic do_xfer(input vec_t v, input string tag);
      int psel_cyc = 0;
      req_valid = 1'b1; req_write = v.wr; req_addr = v.addr;
      req_wdata = v.wdata; req_strb = v.strb;
      @(negedge PCLK);
      chk({tag, ".idle_ready"}, req_ready, 1);
      chk({tag, ".rsp_hold"}, {rsp_valid, rsp_err, rsp_rdata}, {1'b0, last_err, last_rdata});
      @(posedge PCLK); #1;
      req_write = 1'($urandom); req_addr = 12'($urandom);
      req_wdata = $urandom; req_strb = 4'($urandom);
      @(negedge PCLK);
      if (PSEL != 0) psel_cyc++;
      chk({tag, ".setup_ctl"}, {PSEL, PENABLE, req_ready, rsp_valid}, {v.e_psel, 3'b000});
      chk({tag, ".setup_bus"}, {PADDR, PWRITE, PWDATA, PSTRB}, {v.addr, v.wr, v.wdata, v.e_pstrb});
      for (int k = 0; k <= v.nwait; k++) begin
         @(posedge PCLK); #1;
         PREADY  = (k == v.nwait);
         PSLVERR = PREADY ? v.slverr : 1'b1;
         PRDATA  = PREADY ? v.prdata : $urandom;
         @(negedge PCLK);
         if (PSEL != 0) psel_cyc++;
         chk({tag, ".access_ctl"}, {PSEL, PENABLE, req_ready, rsp_valid}, {v.e_psel, 3'b100});
         chk({tag, ".access_bus"}, {PADDR, PWRITE, PWDATA, PSTRB}, {v.addr, v.wr, v.wdata, v.e_pstrb});
      end
      @(posedge PCLK); #1;
      req_valid = 1'b0; PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = $urandom;
      @(negedge PCLK);
      if (PSEL != 0) psel_cyc++;
      chk({tag, ".rsp"}, {rsp_valid, rsp_err, rsp_rdata}, {1'b1, v.e_err, v.e_rdata});
      chk({tag, ".done_ctl"}, {PSEL, PENABLE, req_ready}, {4'b0000, 2'b01});
      chk({tag, ".bus_hold"}, {PADDR, PWRITE, PSTRB}, {v.addr, v.wr, v.e_pstrb});
      chk({tag, ".psel_cycles"}, psel_cyc, v.nwait + 2);
      last_rdata = v.e_rdata;
      last_err   = v.e_err;
      @(posedge PCLK); #1;
   endtask

   initial begin
      int   acc_cyc;
      bit   seen;
      logic got_err;
      logic [31:0] got_rd;

      tbl[0] = '{1'b1, 12'h404, 32'hDEADBEEF, 4'hF, 0, 32'hAAAA5555, 1'b0, 4'b0010, 4'hF, 32'h0, 1'b0};
      tbl[1] = '{1'b0, 12'hC10, 32'h0, 4'h0, 3, 32'h12345678, 1'b0, 4'b1000, 4'h0, 32'h12345678, 1'b0};
      tbl[2] = '{1'b0, 12'h0FC, 32'h99999999, 4'hF, 0, 32'hCAFEF00D, 1'b0, 4'b0001, 4'h0, 32'hCAFEF00D, 1'b0};
      tbl[3] = '{1'b1, 12'h8A0, 32'h01020304, 4'h5, 2, 32'h0, 1'b0, 4'b0100, 4'h5, 32'h0, 1'b0};
      tbl[4] = '{1'b1, 12'h7FF, 32'h11223344, 4'h3, 0, 32'hFFFFFFFF, 1'b1, 4'b0010, 4'h3, 32'h0, 1'b1};
      tbl[5] = '{1'b0, 12'hFFF, 32'h0, 4'h0, 1, 32'h55AA55AA, 1'b1, 4'b1000, 4'h0, 32'h55AA55AA, 1'b1};

      // Reset state
      repeat (3) @(posedge PCLK);
      #1;
      @(negedge PCLK);
      chk("reset_ctl", {req_ready, rsp_valid, rsp_err, PSEL, PENABLE, PWRITE}, {1'b1, 8'h00});
      chk("reset_data", {PADDR, PSTRB, rsp_rdata, PWDATA}, 0);
      @(posedge PCLK); #1;
      PRESETn = 1'b1;
      @(posedge PCLK); #1;

      for (int i = 0; i < 6; i++) do_xfer(tbl[i], $sformatf("vec%0d", i));

      // PREADY stuck low
      req_valid = 1'b1; req_write = 1'b0; req_addr = 12'h400; req_wdata = '0; req_strb = 4'hF;
      @(posedge PCLK); #1;
      req_valid = 1'b0; PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = 32'hFFFF0000;
      acc_cyc = 0; seen = 1'b0; got_err = 1'b0; got_rd = '0;
      for (int c = 0; c < 110 && !seen; c++) begin
         @(negedge PCLK);
         if (rsp_valid) begin
            seen = 1'b1; got_err = rsp_err; got_rd = rsp_rdata;
         end else if (PENABLE && PSEL == 4'b0010) begin
            acc_cyc++;
         end
         @(posedge PCLK); #1;
      end
`ifdef APB_MASTER_TIMEOUT_EN
      chk("tmo_seen", seen, 1);
      chk("tmo_access_cycles", acc_cyc, TMO + 1);
      chk("tmo_rsp", {got_err, got_rd}, {1'b1, 32'h0});
      last_rdata = '0; last_err = 1'b1;
`else
      chk("stuck_no_rsp", seen, 0);
      chk("stuck_access_cycles", acc_cyc, 109);
      PREADY = 1'b1; PRDATA = 32'h0F0F0F0F;
      @(posedge PCLK); #1;
      PREADY = 1'b0;
      @(negedge PCLK);
      chk("stuck_release_rsp", {rsp_valid, rsp_err, rsp_rdata}, {2'b10, 32'h0F0F0F0F});
      last_rdata = 32'h0F0F0F0F; last_err = 1'b0;
      @(posedge PCLK); #1;
`endif

      // Reset during ACCESS, with PREADY offered on the reset edge
      req_valid = 1'b1; req_write = 1'b1; req_addr = 12'h200; req_wdata = 32'h0BADF00D; req_strb = 4'hF;
      @(posedge PCLK); #1;
      req_valid = 1'b0;
      @(posedge PCLK); #1;
      @(posedge PCLK); #1;
      PRESETn = 1'b0; PREADY = 1'b1; PSLVERR = 1'b1;
      @(negedge PCLK);
      chk("pre_reset_access", {PSEL, PENABLE}, {4'b0001, 1'b1});
      @(posedge PCLK); #1;
      PRESETn = 1'b1; PREADY = 1'b0; PSLVERR = 1'b0;
      @(negedge PCLK);
      chk("midreset_ctl", {PSEL, PENABLE, rsp_valid, req_ready, rsp_err}, {4'b0000, 4'b0010});
      chk("midreset_data", {PADDR, rsp_rdata}, 0);
      last_rdata = '0; last_err = 1'b0;
      @(posedge PCLK); #1;
      do_xfer(tbl[0], "post_reset");

      // Random transfers against the model
      for (int i = 0; i < 40; i++) begin
         vec_t v;
         v = model(1'($urandom), 12'($urandom), $urandom, 4'($urandom),
                   int'($urandom_range(0, 3)), $urandom, 1'($urandom));
         do_xfer(v, $sformatf("rnd%0d", i));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/apb_master_ctrl.md
# apb_master_ctrl

Parametrised APB4 master bridge that converts a simple valid/ready request port into APB SETUP/ACCESS transfers toward NSLV slaves. It decodes the slave select from the top address bits and supports write strobes and wait states, with an optional wait-state timeout. It returns one registered response per transfer. It sits between the system-side command source and the APB slave fabric.

## Interface
- ADDR_W, 12, APB address width
- DATA_W, 32, data width; multiple of 8
- NSLV, 4, number of slaves; power of 2, ≥2
- TIMEOUT, 16, maximum ACCESS wait cycles when timeout is compiled in; ≥1

- PCLK  in  1  clock; all logic on rising edge
- PRESETn  in  1  reset, synchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  request accepted when high with req_valid
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  transfer address
- req_wdata  in  DATA_W  write data
- req_strb  in  DATA_W/8  byte strobes
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  DATA_W  read data
- rsp_err  out  1  slave error or timeout
- PSEL  out  NSLV  one-hot slave select
- PENABLE, PWRITE  out  1  APB enable / direction
- PADDR  out  ADDR_W  address
- PWDATA  out  DATA_W  write data
- PSTRB  out  DATA_W/8  write strobes
- PRDATA  in  DATA_W  read data
- PREADY, PSLVERR  in  1  slave ready / error

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- IDLE: req_ready=1. On req_valid, latch the request into PADDR/PWRITE/PWDATA/PSTRB and go to SETUP. PSTRB is forced to 0 for reads.
- SETUP: PSEL[idx]=1 with idx = PADDR[ADDR_W-1 -: $clog2(NSLV)], PENABLE=0. Always proceeds to ACCESS.
- ACCESS: PSEL held and PENABLE=1.
  - PREADY=1: go to IDLE. For reads, capture PRDATA into rsp_rdata; for writes, rsp_rdata=0. rsp_err=PSLVERR.
  - PREADY=0: stay in ACCESS.
- PSLVERR is ignored unless PENABLE & PREADY.
- After a transfer, PSEL and PENABLE return to 0. PADDR/PWRITE/PWDATA/PSTRB hold their last value until the next acceptance.
- rsp_valid pulses for 1 cycle; there is no backpressure on the response port. rsp_rdata and rsp_err hold until the next completion.
- The request inputs are don't-care outside IDLE. req_ready is 0 in SETUP and ACCESS.

## Timing
- Reset values: all outputs 0 except req_ready=1. FSM=IDLE, timeout counter=0.
- Reset is sampled synchronously in any state. A reset asserted mid-transfer drops PSEL/PENABLE on the next edge and suppresses rsp_valid.
- Latency with zero wait states:
  - acceptance edge (cycle 0)
  - SETUP in cycle 1
  - ACCESS in cycle 2
  - rsp_valid and req_ready=1 in cycle 3
- Each PREADY-low cycle in ACCESS adds 1 cycle.
- Throughput is 1 transfer per 3 cycles minimum, with no back-to-back ACCESS→SETUP.
- PADDR, PWRITE, PWDATA and PSTRB are stable from SETUP through the last ACCESS cycle.

## Configuration
- APB_MASTER_TIMEOUT_EN defined: an internal $clog2(TIMEOUT+1)-bit counter is cleared on SETUP and increments on each ACCESS cycle with PREADY=0.
  - When the counter reaches TIMEOUT with PREADY still 0, the transfer aborts: PSEL/PENABLE go to 0 on the next edge, FSM→IDLE, rsp_valid=1, rsp_err=1, rsp_rdata=0.
  - PREADY=1 in the same cycle the count reaches TIMEOUT wins, and the transfer completes normally.
- Undefined: no counter; ACCESS waits indefinitely for PREADY.

## Structure
- Package apb_master_pkg holds:
  - state enum (IDLE/SETUP/ACCESS)
  - strobe-width and select-index-width localparams computed from the parameters
- One sub-module, apb_psel_decode: combinational index→one-hot decode gated by a select-enable input (state≠IDLE).

## Test plan
Configuration for all scenarios: ADDR_W=12, DATA_W=32, NSLV=4, TIMEOUT=8.
- Write addr 0x404, data 0xDEADBEEF, strb 0xF, PREADY=1 → PSEL=4'b0010 in cycles 1–2, PENABLE in cycle 2 only, PSTRB=0xF; rsp_valid in cycle 3 with rsp_err=0.
- Read 0xC10, PREADY low for 3 ACCESS cycles then high, PRDATA=0x12345678 → PSEL=4'b1000 for 5 cycles total; rsp_rdata=0x12345678.
- Read with req_strb=0xF → PSTRB=0, PWRITE=0.
- Write with PSLVERR=1 and PREADY=1 → rsp_err=1. A PSLVERR pulse while PREADY=0 → ignored.
- PREADY stuck low:
  - with APB_MASTER_TIMEOUT_EN: abort after 8 wait cycles, rsp_err=1, rsp_rdata=0.
  - without it: FSM stays in ACCESS for ≥100 cycles.
- PRESETn=0 during ACCESS → next edge PSEL=0, PENABLE=0, no rsp_valid. After release, req_ready=1 and a new write completes normally.
